ifu: RTL and testbench

Instruction fetch unit: the producer side of the instruction interface that the decoder consumes. It holds the PC and issues one word read per instruction on a valid/ready instruction-memory port. It presents each fetched word to the decoder with a valid/ready handshake and advances the PC sequentially or to a redirect target supplied at hand-off. It stops permanently on a halt request or a fetch fault.

---
 rtl/ifu_pkg.sv | 17 +
 rtl/ifu_pc.sv | 52 +++++
 rtl/ifu.sv | 132 +++++++++++++
 tb/tb_ifu.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// ifu_pkg: shared configuration for the instruction fetch unit.
//   ISA_WIDTH / ADDR_WIDTH : architectural word and address width.
//   INST_WIDTH             : width of one fetched instruction word.
//   RESET_VECTOR           : default PC loaded on reset.
//   is_misaligned()        : true when an address is not word aligned.
package ifu_pkg;

  localparam int unsigned ISA_WIDTH    = 32;
  localparam int unsigned ADDR_WIDTH   = ISA_WIDTH;
  localparam int unsigned INST_WIDTH   = 32;
  localparam logic [31:0] RESET_VECTOR = 32'h8000_0000;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/ifu_pc.sv
// ifu_pc: program counter register for the fetch unit.
//   clk_i            : clock
//   rst_ni           : synchronous active-low reset, loads RESET_PC
//   advance_i        : update the PC this cycle (accepted hand-off, no halt)
//   redirect_valid_i : take redirect_pc_i instead of pc+4 on advance
//   redirect_pc_i    : branch/jump target
//   pc_o             : current PC
//   redirect_bad_o   : redirect requested to a non word-aligned target
module ifu_pc
  import ifu_pkg::*;
#(
  parameter int unsigned              ADDR_WIDTH = ifu_pkg::ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0]    RESET_PC   = ADDR_WIDTH'(ifu_pkg::RESET_VECTOR)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  advance_i,
  input  logic                  redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  redirect_bad_o
);

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc_d;
  logic [ADDR_WIDTH-1:0] pc_seq;

  // Sequential successor wraps naturally modulo 2^ADDR_WIDTH.
  assign pc_seq = pc_q + ADDR_WIDTH'(4);

  // A misaligned redirect still loads the target so the halted PC
  // reports the offending address.
  always_comb begin
    pc_d = pc_q;
    if (advance_i) begin
      pc_d = redirect_valid_i ? redirect_pc_i : pc_seq;
    end
  end

  assign redirect_bad_o = redirect_valid_i && is_misaligned(redirect_pc_i[1:0]);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/ifu.sv
// ifu: instruction fetch unit.
// Issues one read per instruction on the imem request port, holds the
// returned word for the decoder under a valid/ready handshake, then
// advances the PC sequentially or to a redirect target. Halts for good
// on a halt request or on a fetch/redirect fault.
//   imem_req_*     : request port (valid/ready, addr = pc)
//   imem_rsp_*     : response (one valid pulse per request, err = fault)
//   inst_valid/ready, inst, pc : decoder hand-off
//   redirect_valid/pc, halt    : sampled only on an inst handshake
//   halted, fault  : halt status; fetch_cnt counts inst handshakes
// All outputs come from registers; no input reaches an output directly.
module ifu
  import ifu_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = ifu_pkg::ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(ifu_pkg::RESET_VECTOR)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [31:0]           imem_rsp_data,
  input  logic                  imem_rsp_err,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [31:0]           inst,
  output logic [ADDR_WIDTH-1:0] pc,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  halt,
  output logic                  halted,
  output logic                  fault,
  output logic [31:0]           fetch_cnt
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
  localparam logic [2:0] S_HALT = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] cnt_q, cnt_d;
  logic        fault_q, fault_d;

  logic        handshake;
  logic        advance;
  logic        redirect_bad;

  assign handshake = (state_q == S_HOLD) && inst_ready;
  assign advance   = handshake && !halt;

  ifu_pc #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc (
    .clk_i            (clk),
    .rst_ni           (rst),
    .advance_i        (advance),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .pc_o             (pc),
    .redirect_bad_o   (redirect_bad)
  );

  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (imem_rsp_err) begin
            state_d = S_HALT;
            fault_d = 1'b1;
          end else begin
            inst_d  = imem_rsp_data;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (inst_ready) begin
          cnt_d = cnt_q + 32'd1;
          if (halt) begin
            state_d = S_HALT;
          end else if (redirect_bad) begin
            state_d = S_HALT;
            fault_d = 1'b1;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      inst_q  <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = pc;
  assign inst_valid     = (state_q == S_HOLD);
  assign inst           = inst_q;
  assign halted         = (state_q == S_HALT);
  assign fault          = fault_q;
  assign fetch_cnt      = cnt_q;

endmodule

// File: tb/tb_ifu.sv
// tb_ifu: self-checking bench for ifu. A memory responder answers each
// accepted request after a programmable latency; a transaction-level model
// tracks what the fetch unit owes the decoder and is compared every cycle,
// while directed scenarios pin timing and values with literal expectations.
module tb_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        halted;
  logic        fault;
  logic [31:0] fetch_cnt;

  always #5 clk = ~clk;

  ifu #(
    .ADDR_WIDTH (32),
    .RESET_PC   (32'h8000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .pc             (pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .halted         (halted),
    .fault          (fault),
    .fetch_cnt      (fetch_cnt)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], 16'h0013};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- memory responder ----------------
  int          lat      = 1;
  int          pend     = 0;
  logic [31:0] pend_addr = '0;
  logic [31:0] err_addr  = 32'hFFFF_FFFF;

  always @(posedge clk) begin
    cyc++;
    if (rst && imem_req_valid && imem_req_ready) begin
      pend      = lat;
      pend_addr = imem_req_addr;
    end
  end

  always @(negedge clk) begin
    imem_rsp_valid = 1'b0;
    imem_rsp_err   = 1'b0;
    imem_rsp_data  = 32'hDEAD_BEEF;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem(pend_addr);
        imem_rsp_err   = (pend_addr == err_addr);
      end
    end
  end

  // ---------------- transaction-level model ----------------
  logic        m_ok = 1'b0;
  logic        m_idle, m_out, m_have, m_halted, m_fault;
  logic [31:0] m_pc, m_inst, m_cnt;

  always @(posedge clk) begin
    if (!rst) begin
      m_ok = 1'b1; m_idle = 1'b1; m_out = 1'b0; m_have = 1'b0;
      m_halted = 1'b0; m_fault = 1'b0;
      m_pc = 32'h8000_0000; m_inst = '0; m_cnt = '0;
    end else if (m_ok) begin
      if (m_idle) begin
        m_idle = 1'b0;
      end else if (m_halted) begin
        m_halted = 1'b1;
      end else if (m_out) begin
        if (imem_rsp_valid) begin
          m_out = 1'b0;
          if (imem_rsp_err) begin
            m_halted = 1'b1; m_fault = 1'b1;
          end else begin
            m_have = 1'b1; m_inst = mem(m_pc);
          end
        end
      end else if (m_have) begin
        if (inst_ready) begin
          m_cnt  = m_cnt + 32'd1;
          m_have = 1'b0;
          if (halt) begin
            m_halted = 1'b1;
          end else if (redirect_valid && redirect_pc[1:0] != 2'b00) begin
            m_halted = 1'b1; m_fault = 1'b1; m_pc = redirect_pc;
          end else begin
            m_pc = redirect_valid ? redirect_pc : m_pc + 32'd4;
          end
        end
      end else if (imem_req_ready) begin
        m_out = 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_ok) begin
      chk("m_req_valid", 32'(imem_req_valid), 32'(!m_idle && !m_halted && !m_out && !m_have));
      if (imem_req_valid) chk("m_req_addr", imem_req_addr, m_pc);
      chk("m_inst_valid", 32'(inst_valid), 32'(m_have));
      chk("m_inst", inst, m_inst);
      chk("m_pc", pc, m_pc);
      chk("m_halted", 32'(halted), 32'(m_halted));
      chk("m_fault", 32'(fault), 32'(m_fault));
      chk("m_fetch_cnt", fetch_cnt, m_cnt);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic idle_inputs();
    inst_ready     = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h1234_5673;
    halt           = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_inst(input string name);
    int n = 0;
    while (!inst_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_tmo"}, 32'(inst_valid), 32'd1);
  endtask

  task automatic handshake(input logic rv, input logic [31:0] rpc, input logic h);
    inst_ready     = 1'b1;
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt           = h;
    @(negedge clk);
    idle_inputs();
  endtask

  int t0, t1, t2;

  initial begin
    rst = 1'b0;
    imem_req_ready = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);

    // T1: basic sequential fetch and cadence
    rst = 1'b1;
    chk("idle_req_valid", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("first_req_addr", imem_req_addr, 32'h8000_0000);
    wait_inst("t1a");
    t0 = cyc;
    chk("t1a_pc", pc, 32'h8000_0000);
    chk("t1a_inst", inst, 32'h0000_0013);
    handshake(1'b0, 32'h0, 1'b0);
    wait_inst("t1b");
    t1 = cyc;
    chk("cadence_1", 32'(t1 - t0), 32'd3);
    chk("t1b_pc", pc, 32'h8000_0004);
    chk("t1b_inst", inst, 32'h0004_0013);
    chk("t1b_cnt", fetch_cnt, 32'd1);
    handshake(1'b0, 32'h0, 1'b0);
    wait_inst("t1c");
    t2 = cyc;
    chk("cadence_2", 32'(t2 - t1), 32'd3);
    chk("t1c_pc", pc, 32'h8000_0008);

    // T2: request back-pressure
    imem_req_ready = 1'b0;
    handshake(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("bp_req_valid", 32'(imem_req_valid), 32'd1);
      chk("bp_req_addr", imem_req_addr, 32'h8000_000C);
      chk("bp_inst_valid", 32'(inst_valid), 32'd0);
      @(negedge clk);
    end
    imem_req_ready = 1'b1;

    // T3: decoder stall, then redirect
    wait_inst("t3");
    chk("t3_cnt", fetch_cnt, 32'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(inst_valid), 32'd1);
      chk("stall_pc", pc, 32'h8000_000C);
      chk("stall_inst", inst, 32'h000C_0013);
      chk("stall_cnt", fetch_cnt, 32'd3);
    end
    handshake(1'b1, 32'h8000_0100, 1'b0);
    chk("redir_cnt", fetch_cnt, 32'd4);
    chk("redir_req_valid", 32'(imem_req_valid), 32'd1);
    chk("redir_req_addr", imem_req_addr, 32'h8000_0100);

    // T4: misaligned redirect faults
    wait_inst("t4");
    chk("t4_inst", inst, 32'h0100_0013);
    handshake(1'b1, 32'h8000_0102, 1'b0);
    chk("mis_halted", 32'(halted), 32'd1);
    chk("mis_fault", 32'(fault), 32'd1);
    chk("mis_pc", pc, 32'h8000_0102);
    chk("mis_cnt", fetch_cnt, 32'd5);
    repeat (4) begin
      @(negedge clk);
      chk("mis_no_req", 32'(imem_req_valid), 32'd0);
    end

    // T5: wrap of pc+4, then halt beats redirect
    do_reset();
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_cnt", fetch_cnt, 32'd0);
    chk("rst_pc", pc, 32'h8000_0000);
    chk("rst_inst", inst, 32'h0);
    wait_inst("t5a");
    handshake(1'b1, 32'hFFFF_FFFC, 1'b0);
    wait_inst("t5b");
    chk("top_pc", pc, 32'hFFFF_FFFC);
    chk("top_inst", inst, 32'hFFFC_0013);
    handshake(1'b0, 32'h0, 1'b0);
    chk("wrap_req_valid", 32'(imem_req_valid), 32'd1);
    chk("wrap_req_addr", imem_req_addr, 32'h0);
    wait_inst("t5c");
    chk("wrap_inst", inst, 32'h0000_0013);
    chk("wrap_cnt", fetch_cnt, 32'd2);
    handshake(1'b1, 32'h8000_0200, 1'b1);
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_fault", 32'(fault), 32'd0);
    chk("halt_pc", pc, 32'h0);
    chk("halt_cnt", fetch_cnt, 32'd3);
    repeat (3) begin
      @(negedge clk);
      chk("halt_no_req", 32'(imem_req_valid), 32'd0);
    end

    // T6: access fault on a response
    do_reset();
    err_addr = 32'h8000_0004;
    wait_inst("t6");
    handshake(1'b0, 32'h0, 1'b0);
    for (int n = 0; n < 40 && !halted; n++) @(negedge clk);
    chk("err_halted", 32'(halted), 32'd1);
    chk("err_fault", 32'(fault), 32'd1);
    chk("err_cnt", fetch_cnt, 32'd1);
    chk("err_inst_valid", 32'(inst_valid), 32'd0);
    err_addr = 32'hFFFF_FFFF;

    // T7: reset during WAIT, stray response dropped
    lat = 4;
    do_reset();
    @(negedge clk);
    chk("t7_req", 32'(imem_req_valid), 32'd1);
    @(negedge clk);
    chk("t7_wait_req", 32'(imem_req_valid), 32'd0);
    chk("t7_wait_inst", 32'(inst_valid), 32'd0);
    rst = 1'b0;
    imem_req_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("stray_inst_valid", 32'(inst_valid), 32'd0);
    end
    chk("stray_req_addr", imem_req_addr, 32'h8000_0000);
    lat = 1;
    imem_req_ready = 1'b1;
    wait_inst("t7");
    chk("t7_pc", pc, 32'h8000_0000);
    chk("t7_inst", inst, 32'h0000_0013);
    chk("t7_cnt", fetch_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "tb_ifu timeout");
  end

endmodule
